// File: rtl/conv_fc_stream.sv
// conv_fc_stream: streaming conv + fully-connected classifier engine.
//
// One K-tap window is accepted per valid/ready handshake. Each window becomes
// one conv output (window . kernel + bias). That output is requantised
// (arithmetic right shift, optional ReLU) and multiply-accumulated into N_CLS
// FC accumulators. The FC weights come from an external 1-cycle-latency ROM.
// After N_POS windows the engine walks the classes one per cycle. It adds the
// FC bias, tracks the argmax, and then presents scores plus index on a
// valid/ready output.
//
// Ports
//   i_clk, i_rstn            clock, synchronous active-low reset
//   i_win_valid/o_win_ready  window handshake; i_win = K signed taps, tap 0 in LSBs
//   i_kernel, i_conv_bias    conv kernel taps and bias (signed, static per inference)
//   i_shift, i_relu_en       requant shift amount and ReLU enable
//   o_fc_addr/i_fc_weight    FC weight ROM row address / row data (next cycle)
//   i_fc_bias                per-class FC bias, ACC_W signed each
//   o_res_valid/i_res_ready  result handshake
//   o_res, o_argmax          class scores (class 0 in LSBs) and index of max score
//   o_busy                   high whenever the engine is not in IDLE

// Per-class FC lane: next accumulator value and final score for one class.
module conv_fc_lane #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 32
) (
  input  logic signed [ACC_W-1:0] i_acc,
  input  logic signed [ACC_W-1:0] i_v,
  input  logic signed [IN_W-1:0]  i_w,
  input  logic signed [ACC_W-1:0] i_bias,
  output logic        [ACC_W-1:0] o_acc_nxt,
  output logic        [ACC_W-1:0] o_score
);
  logic signed [ACC_W-1:0] w_ext;

  assign w_ext     = ACC_W'(i_w);
  // Both results wrap modulo 2^ACC_W; there is no saturation.
  assign o_acc_nxt = i_acc + i_v * w_ext;
  assign o_score   = i_acc + i_bias;
endmodule

module conv_fc_stream #(
  parameter int K     = 9,
  parameter int N_POS = 26,
  parameter int N_CLS = 10,
  parameter int IN_W  = 8,
  parameter int ACC_W = 32,
  parameter int SH_W  = 5,
  localparam int PA_W  = (N_POS > 1) ? $clog2(N_POS) : 1,
  localparam int CLS_W = (N_CLS > 1) ? $clog2(N_CLS) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_win_valid,
  output logic                   o_win_ready,
  input  logic [K*IN_W-1:0]      i_win,
  input  logic [K*IN_W-1:0]      i_kernel,
  input  logic [IN_W-1:0]        i_conv_bias,
  input  logic [SH_W-1:0]        i_shift,
  input  logic                   i_relu_en,
  output logic [PA_W-1:0]        o_fc_addr,
  input  logic [N_CLS*IN_W-1:0]  i_fc_weight,
  input  logic [N_CLS*ACC_W-1:0] i_fc_bias,
  output logic                   o_res_valid,
  input  logic                   i_res_ready,
  output logic [N_CLS*ACC_W-1:0] o_res,
  output logic [CLS_W-1:0]       o_argmax,
  output logic                   o_busy
);
  // The position counter must also hold N_POS itself ("all windows taken").
  localparam int CNT_W = $clog2(N_POS + 1);
  localparam logic [CNT_W-1:0] POS_LAST = CNT_W'(N_POS - 1);
  localparam logic [CNT_W-1:0] POS_END  = CNT_W'(N_POS);
  localparam logic [CLS_W-1:0] CLS_LAST = CLS_W'(N_CLS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SCAN, S_DONE} state_t;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               pos_q, pos_d;
  logic [CLS_W-1:0]               cls_q, cls_d;
  logic signed [ACC_W-1:0]        conv_q, conv_d;
  logic                           s1_vld_q, s1_vld_d;
  logic                           s1_last_q, s1_last_d;
  logic [N_CLS-1:0][ACC_W-1:0]    acc_q, acc_d;
  logic [N_CLS-1:0][ACC_W-1:0]    res_q, res_d;
  logic signed [ACC_W-1:0]        max_q, max_d;
  logic [CLS_W-1:0]               argmax_q, argmax_d;
  logic                           res_valid_q, res_valid_d;
  logic                           win_ready_q, win_ready_d;
  logic                           busy_q, busy_d;

  logic                           win_fire, res_fire;
  logic signed [ACC_W-1:0]        conv_sum, tap_e, kern_e;
  logic signed [ACC_W-1:0]        v_shift, v;
  logic [N_CLS-1:0][ACC_W-1:0]    acc_nxt, score;
  logic signed [ACC_W-1:0]        score_sel;

  assign win_fire = i_win_valid & win_ready_q;
  assign res_fire = res_valid_q & i_res_ready;

  // Stage 1 datapath: K-tap signed dot product plus bias, computed at ACC_W.
  // Sign-extending every operand to ACC_W first gives exactly the truncated
  // full-precision sum.
  always_comb begin
    tap_e    = '0;
    kern_e   = '0;
    conv_sum = ACC_W'(signed'(i_conv_bias));
    for (int k = 0; k < K; k++) begin
      tap_e    = ACC_W'(signed'(i_win[k*IN_W +: IN_W]));
      kern_e   = ACC_W'(signed'(i_kernel[k*IN_W +: IN_W]));
      conv_sum = conv_sum + tap_e * kern_e;
    end
  end

  // Stage 2 requant: arithmetic shift, then optional clamp at zero.
  always_comb begin
    v_shift = conv_q >>> i_shift;
    v       = (i_relu_en && v_shift[ACC_W-1]) ? '0 : v_shift;
  end

  for (genvar c = 0; c < N_CLS; c++) begin : g_lane
    conv_fc_lane #(.IN_W(IN_W), .ACC_W(ACC_W)) u_lane (
      .i_acc     (acc_q[c]),
      .i_v       (v),
      .i_w       (i_fc_weight[c*IN_W +: IN_W]),
      .i_bias    (i_fc_bias[c*ACC_W +: ACC_W]),
      .o_acc_nxt (acc_nxt[c]),
      .o_score   (score[c])
    );
  end

  assign score_sel = score[cls_q];

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    cls_d       = cls_q;
    conv_d      = conv_q;
    s1_vld_d    = 1'b0;
    s1_last_d   = s1_last_q;
    acc_d       = acc_q;
    res_d       = res_q;
    max_d       = max_q;
    argmax_d    = argmax_q;
    res_valid_d = res_valid_q;
    case (state_q)
      S_IDLE: state_d = S_ACCUM;
      S_ACCUM: begin
        if (win_fire) begin
          pos_d     = pos_q + CNT_W'(1);
          conv_d    = conv_sum;
          s1_vld_d  = 1'b1;
          s1_last_d = (pos_q == POS_LAST);
        end
        // The ROM row for this window was addressed on its fire cycle, so it
        // is on i_fc_weight now, alongside conv_q.
        if (s1_vld_q) begin
          acc_d = acc_nxt;
          if (s1_last_q) begin
            state_d = S_SCAN;
            cls_d   = '0;
          end
        end
      end
      S_SCAN: begin
        res_d[cls_q] = score_sel;
        // Class 0 seeds the running max; later classes replace it only when
        // strictly greater, so ties keep the lowest index.
        if ((cls_q == '0) || (score_sel > max_q)) begin
          max_d    = score_sel;
          argmax_d = cls_q;
        end
        if (cls_q == CLS_LAST) begin
          state_d     = S_DONE;
          res_valid_d = 1'b1;
        end else begin
          cls_d = cls_q + CLS_W'(1);
        end
      end
      S_DONE: begin
        if (res_fire) begin
          state_d     = S_ACCUM;
          res_valid_d = 1'b0;
          acc_d       = '0;
          pos_d       = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // These outputs are registered from next-state values, so they track the
    // current state/counter exactly without combinational paths.
    win_ready_d = (state_d == S_ACCUM) && (pos_d < POS_END);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q     <= S_IDLE;
      pos_q       <= '0;
      cls_q       <= '0;
      conv_q      <= '0;
      s1_vld_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      acc_q       <= '0;
      res_q       <= '0;
      max_q       <= '0;
      argmax_q    <= '0;
      res_valid_q <= 1'b0;
      win_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      cls_q       <= cls_d;
      conv_q      <= conv_d;
      s1_vld_q    <= s1_vld_d;
      s1_last_q   <= s1_last_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      max_q       <= max_d;
      argmax_q    <= argmax_d;
      res_valid_q <= res_valid_d;
      win_ready_q <= win_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign o_win_ready = win_ready_q;
  assign o_fc_addr   = pos_q[PA_W-1:0];
  assign o_res_valid = res_valid_q;
  assign o_res       = res_q;
  assign o_argmax    = argmax_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_conv_fc_stream.sv
module tb_conv_fc_stream;
  localparam int K     = 9;
  localparam int N_POS = 26;
  localparam int N_CLS = 10;
  localparam int IN_W  = 8;
  localparam int ACC_W = 32;
  localparam int SH_W  = 5;
  localparam int PA_W  = $clog2(N_POS);
  localparam int CLS_W = $clog2(N_CLS);

  logic                   clk = 1'b0;
  logic                   rstn = 1'b0;
  logic                   i_win_valid = 1'b0;
  logic                   o_win_ready;
  logic [K*IN_W-1:0]      i_win = '0;
  logic [K*IN_W-1:0]      i_kernel = '0;
  logic [IN_W-1:0]        i_conv_bias = '0;
  logic [SH_W-1:0]        i_shift = '0;
  logic                   i_relu_en = 1'b0;
  logic [PA_W-1:0]        o_fc_addr;
  logic [N_CLS*IN_W-1:0]  i_fc_weight = '0;
  logic [N_CLS*ACC_W-1:0] i_fc_bias = '0;
  logic                   o_res_valid;
  logic                   i_res_ready = 1'b0;
  logic [N_CLS*ACC_W-1:0] o_res;
  logic [CLS_W-1:0]       o_argmax;
  logic                   o_busy;

  conv_fc_stream #(.K(K), .N_POS(N_POS), .N_CLS(N_CLS), .IN_W(IN_W),
                   .ACC_W(ACC_W), .SH_W(SH_W)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_win_valid(i_win_valid), .o_win_ready(o_win_ready),
    .i_win(i_win), .i_kernel(i_kernel), .i_conv_bias(i_conv_bias), .i_shift(i_shift),
    .i_relu_en(i_relu_en), .o_fc_addr(o_fc_addr), .i_fc_weight(i_fc_weight),
    .i_fc_bias(i_fc_bias), .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
    .o_res(o_res), .o_argmax(o_argmax), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scenario data
  byte win_m [N_POS][K];
  byte kern_m[K];
  byte wt_m  [N_POS][N_CLS];
  int  fcb_m [N_CLS];
  byte cbias;
  int  shift;
  bit  relu;
  int  exp_res[N_CLS];
  int  exp_arg;

  // External FC weight ROM: registered read, one cycle of latency.
  always @(posedge clk) begin
    for (int c = 0; c < N_CLS; c++)
      i_fc_weight[c*IN_W +: IN_W] <= (int'(o_fc_addr) < N_POS) ? wt_m[o_fc_addr][c] : 8'sd0;
  end

  function automatic logic [K*IN_W-1:0] pack_win(input int p);
    logic [K*IN_W-1:0] r;
    for (int k = 0; k < K; k++) r[k*IN_W +: IN_W] = win_m[p][k];
    return r;
  endfunction

  task automatic apply_cfg();
    for (int k = 0; k < K; k++) i_kernel[k*IN_W +: IN_W] = kern_m[k];
    for (int c = 0; c < N_CLS; c++) i_fc_bias[c*ACC_W +: ACC_W] = fcb_m[c];
    i_conv_bias = cbias;
    i_shift     = SH_W'(shift);
    i_relu_en   = relu;
  endtask

  task automatic set_uniform(input byte tap, input byte kern, input byte wt_all, input int hot);
    // hot >= 0: weight is 1 only for that class, else wt_all everywhere
    for (int p = 0; p < N_POS; p++) begin
      for (int k = 0; k < K; k++) win_m[p][k] = tap;
      for (int c = 0; c < N_CLS; c++) wt_m[p][c] = (hot >= 0) ? ((c == hot) ? 8'sd1 : 8'sd0) : wt_all;
    end
    for (int k = 0; k < K; k++) kern_m[k] = kern;
    for (int c = 0; c < N_CLS; c++) fcb_m[c] = 0;
    cbias = 0; shift = 0; relu = 0;
  endtask

  // Golden model: whole inference with plain 32-bit integer arithmetic
  // (int wraps modulo 2^32, matching ACC_W).
  task automatic model_run();
    int acc[N_CLS];
    int conv, v;
    for (int c = 0; c < N_CLS; c++) acc[c] = 0;
    for (int p = 0; p < N_POS; p++) begin
      conv = int'(cbias);
      for (int k = 0; k < K; k++) conv += int'(win_m[p][k]) * int'(kern_m[k]);
      v = conv >>> shift;
      if (relu && v < 0) v = 0;
      for (int c = 0; c < N_CLS; c++) acc[c] += v * int'(wt_m[p][c]);
    end
    exp_arg = 0;
    for (int c = 0; c < N_CLS; c++) begin
      exp_res[c] = acc[c] + fcb_m[c];
      if (exp_res[c] > exp_res[exp_arg]) exp_arg = c;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; i_win_valid = 1'b0; i_res_ready = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
  endtask

  // Feed windows 0..n-1; returns the cycle count taken just after the last fire.
  task automatic feed(input int n, input bit gaps, output int fire_cyc);
    int wd;
    fire_cyc = cyc;
    @(negedge clk);
    for (int p = 0; p < n; p++) begin
      if (gaps) begin
        i_win_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      i_win = pack_win(p);
      i_win_valid = 1'b1;
      wd = 0;
      while (!o_win_ready && wd < 200) begin @(negedge clk); wd++; end
      if (wd >= 200) begin
        n_tests++; n_fail++;
        $display("FAIL feed_timeout pos=%0d o_win_ready=%b required 1", p, o_win_ready);
        i_win_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      fire_cyc = cyc;
      @(negedge clk);
    end
    i_win_valid = 1'b0;
  endtask

  task automatic wait_res(input int fire_cyc, output int lat);
    int wd = 0;
    while (!o_res_valid && wd < 200) begin @(negedge clk); wd++; end
    lat = cyc - fire_cyc;
    if (!o_res_valid) begin
      n_tests++; n_fail++;
      $display("FAIL res_timeout o_res_valid=%b required 1", o_res_valid);
    end
  endtask

  task automatic release_res(input int delay);
    repeat (delay) @(negedge clk);
    i_res_ready = 1'b1;
    @(negedge clk);
    i_res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({o_res_valid, o_win_ready, o_busy} !== 3'b000 || o_res !== '0 || o_argmax !== '0 || o_fc_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_state valid/ready/busy=%b res_nz=%b argmax=%0d addr=%0d required 000,0,0,0",
               {o_res_valid, o_win_ready, o_busy}, (o_res != '0), o_argmax, o_fc_addr);
    end
    rstn = 1'b1;
    @(negedge clk);   // one edge after release: was still IDLE going into it
    @(negedge clk);
    n_tests++;
    if (o_win_ready !== 1'b1 || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_exit ready=%b busy=%b required 1 1", o_win_ready, o_busy);
    end
  endtask

  task automatic test_onehot();
    int fc, lat;
    set_uniform(8'sd1, 8'sd1, 8'sd0, 3);
    apply_cfg();
    feed(N_POS, 1'b0, fc);
    wait_res(fc, lat);
    for (int c = 0; c < N_CLS; c++) begin
      n_tests++;
      if ($signed(o_res[c*ACC_W +: ACC_W]) !== ((c == 3) ? 234 : 0)) begin
        n_fail++;
        $display("FAIL onehot_score[%0d] got %0d required %0d", c, $signed(o_res[c*ACC_W +: ACC_W]), (c == 3) ? 234 : 0);
      end
    end
    n_tests++;
    if (o_argmax !== 4'd3) begin n_fail++; $display("FAIL onehot_argmax got %0d required 3", o_argmax); end
    release_res(0);
  endtask

  task automatic test_relu_tie();
    int fc, lat;
    set_uniform(8'sd1, -8'sd1, 8'sd0, 3);
    relu = 1;
    apply_cfg();
    feed(N_POS, 1'b0, fc);
    wait_res(fc, lat);
    n_tests++;
    if (o_res !== '0) begin n_fail++; $display("FAIL relu_scores got nonzero %h required 0", o_res); end
    n_tests++;
    if (o_argmax !== 4'd0) begin n_fail++; $display("FAIL relu_tie_argmax got %0d required 0", o_argmax); end
    release_res(0);
  endtask

  task automatic cfg_shift_bias();
    set_uniform(8'sd16, 8'sd1, 8'sd1, -1);
    shift = 4;
    for (int c = 0; c < N_CLS; c++) fcb_m[c] = c;
    apply_cfg();
  endtask

  task automatic test_shift_bias();
    int fc, lat;
    cfg_shift_bias();
    feed(N_POS, 1'b0, fc);
    wait_res(fc, lat);
    for (int c = 0; c < N_CLS; c++) begin
      n_tests++;
      if ($signed(o_res[c*ACC_W +: ACC_W]) !== 234 + c) begin
        n_fail++;
        $display("FAIL shift_score[%0d] got %0d required %0d", c, $signed(o_res[c*ACC_W +: ACC_W]), 234 + c);
      end
    end
    n_tests++;
    if (o_argmax !== 4'd9) begin n_fail++; $display("FAIL shift_argmax got %0d required 9", o_argmax); end
    release_res(0);
  endtask

  task automatic test_back_to_back();
    int fc, lat;
    logic [N_CLS*ACC_W-1:0] snap;
    cfg_shift_bias();
    feed(N_POS, 1'b0, fc);
    wait_res(fc, lat);
    // Last fire at edge E0; valid first visible after edge E0+1+N_CLS.
    n_tests++;
    if (lat !== N_CLS + 1) begin n_fail++; $display("FAIL b2b_latency got %0d edges required %0d", lat, N_CLS + 1); end
    snap = o_res;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (o_res !== snap || o_win_ready !== 1'b0 || o_res_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_cycle%0d res_changed=%b ready=%b valid=%b required 0 0 1",
                 i, (o_res !== snap), o_win_ready, o_res_valid);
      end
    end
    release_res(0);
    model_run();
    for (int r = 0; r < 2; r++) begin
      feed(N_POS, 1'b1, fc);
      wait_res(fc, lat);
      for (int c = 0; c < N_CLS; c++) begin
        n_tests++;
        if (o_res[c*ACC_W +: ACC_W] !== exp_res[c]) begin
          n_fail++;
          $display("FAIL gaps%0d_score[%0d] got %0d required %0d", r, c, $signed(o_res[c*ACC_W +: ACC_W]), exp_res[c]);
        end
      end
      n_tests++;
      if (o_argmax !== CLS_W'(exp_arg)) begin n_fail++; $display("FAIL gaps%0d_argmax got %0d required %0d", r, o_argmax, exp_arg); end
      release_res($urandom_range(0, 4));
    end
  endtask

  task automatic test_wrap();
    int fc, lat;
    set_uniform(8'sd127, 8'sd127, 8'sd127, -1);
    for (int r = 0; r < 2; r++) begin
      // Second pass pushes large FC biases so scores overflow past 2^31.
      for (int c = 0; c < N_CLS; c++) fcb_m[c] = (r == 0) ? 0 : int'(32'h7000_0000) + c * 32'h0100_0000;
      apply_cfg();
      model_run();
      feed(N_POS, 1'b0, fc);
      wait_res(fc, lat);
      for (int c = 0; c < N_CLS; c++) begin
        n_tests++;
        if (o_res[c*ACC_W +: ACC_W] !== exp_res[c]) begin
          n_fail++;
          $display("FAIL wrap%0d_score[%0d] got %0d required %0d", r, c, $signed(o_res[c*ACC_W +: ACC_W]), exp_res[c]);
        end
      end
      n_tests++;
      if (o_argmax !== CLS_W'(exp_arg)) begin n_fail++; $display("FAIL wrap%0d_argmax got %0d required %0d", r, o_argmax, exp_arg); end
      release_res(0);
    end
  endtask

  task automatic test_reset_mid();
    int fc, lat;
    set_uniform(8'sd1, 8'sd1, 8'sd0, 3);
    apply_cfg();
    feed(10, 1'b0, fc);
    do_reset();
    @(negedge clk);
    n_tests++;
    if (o_res_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid got %b required 0", o_res_valid); end
    feed(N_POS, 1'b0, fc);
    wait_res(fc, lat);
    for (int c = 0; c < N_CLS; c++) begin
      n_tests++;
      if ($signed(o_res[c*ACC_W +: ACC_W]) !== ((c == 3) ? 234 : 0)) begin
        n_fail++;
        $display("FAIL midreset_score[%0d] got %0d required %0d", c, $signed(o_res[c*ACC_W +: ACC_W]), (c == 3) ? 234 : 0);
      end
    end
    n_tests++;
    if (o_argmax !== 4'd3) begin n_fail++; $display("FAIL midreset_argmax got %0d required 3", o_argmax); end
    release_res(0);
  endtask

  task automatic test_random();
    int fc, lat;
    for (int it = 0; it < 4; it++) begin
      for (int p = 0; p < N_POS; p++) begin
        for (int k = 0; k < K; k++) win_m[p][k] = byte'($urandom);
        for (int c = 0; c < N_CLS; c++) wt_m[p][c] = byte'($urandom);
      end
      for (int k = 0; k < K; k++) kern_m[k] = byte'($urandom);
      for (int c = 0; c < N_CLS; c++) fcb_m[c] = int'($urandom);
      cbias = byte'($urandom);
      shift = $urandom_range(0, 6);
      relu  = 1'($urandom);
      apply_cfg();
      model_run();
      feed(N_POS, 1'b1, fc);
      wait_res(fc, lat);
      for (int c = 0; c < N_CLS; c++) begin
        n_tests++;
        if (o_res[c*ACC_W +: ACC_W] !== exp_res[c]) begin
          n_fail++;
          $display("FAIL rand%0d_score[%0d] got %0d required %0d", it, c, $signed(o_res[c*ACC_W +: ACC_W]), exp_res[c]);
        end
      end
      n_tests++;
      if (o_argmax !== CLS_W'(exp_arg)) begin n_fail++; $display("FAIL rand%0d_argmax got %0d required %0d", it, o_argmax, exp_arg); end
      release_res($urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_onehot();
    test_relu_tie();
    test_shift_bias();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout reached required finish");
    $fatal(1);
  end
endmodule
